// File: rtl/vga_bar_renderer.sv
// vga_bar_renderer: VGA sync generator drawing frame-latched spectrum bars with peak-hold markers
module vga_bar_renderer #(
    parameter int HPIXELS     = 640,
    parameter int HFP         = 16,
    parameter int HPULSE      = 96,
    parameter int HBP         = 48,
    parameter int VLINES      = 480,
    parameter int VFP         = 10,
    parameter int VPULSE      = 2,
    parameter int VBP         = 33,
    parameter int NUM_BARS    = 16,
    parameter int BAR_W       = 18,
    parameter int SCALE_SHIFT = 9,
    parameter int GAP         = 2,
    parameter int PEAK_HOLD   = 30,
    parameter int PEAK_DECAY  = 2
) (
    input  logic                           vgaclk,
    input  logic                           rst_n,
    input  logic [NUM_BARS-1:0][BAR_W-1:0] bars,
    input  logic [1:0]                     mode,
    output logic                           hsync,
    output logic                           vsync,
    output logic [3:0]                     red,
    output logic [3:0]                     green,
    output logic [3:0]                     blue,
    output logic                           frame_start
);
    localparam int HTOTAL = HPIXELS + HFP + HPULSE + HBP;
    localparam int VTOTAL = VLINES + VFP + VPULSE + VBP;
    localparam int HW = $clog2(HTOTAL + 1);
    localparam int VW = $clog2(VTOTAL + 1);
    localparam int PW = $clog2(VLINES + 1);
    localparam int TW = $clog2(PEAK_HOLD + 2);
    localparam int IW = $clog2(NUM_BARS);
    localparam int BW = HPIXELS / NUM_BARS;
    localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ACT = HW'(HPIXELS);
    localparam logic [HW-1:0] HS_ON = HW'(HPIXELS + HFP);
    localparam logic [HW-1:0] HS_OFF = HW'(HPIXELS + HFP + HPULSE);
    localparam logic [HW-1:0] H_BW = HW'(BW);
    localparam logic [HW-1:0] H_LIT = HW'(BW - GAP);
    localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(VLINES);
    localparam logic [VW-1:0] VS_ON = VW'(VLINES + VFP);
    localparam logic [VW-1:0] VS_OFF = VW'(VLINES + VFP + VPULSE);
    localparam logic [VW-1:0] V_BAND = VW'(VLINES / 16);
    localparam logic [VW-1:0] V_15 = VW'(15);
    localparam logic [PW-1:0] P_MAX = PW'(VLINES);
    localparam logic [PW-1:0] P_DEC = PW'(PEAK_DECAY);
    localparam logic [BAR_W-1:0] S_MAX = BAR_W'(VLINES);
    localparam logic [TW-1:0] T_HOLD = TW'(PEAK_HOLD);

    logic [HW-1:0] hc_q, hc_d, col;
    logic [VW-1:0] vc_q, vc_d, bar_top, pk_row;
    logic [NUM_BARS-1:0][PW-1:0] h_q, h_d, peak_q, peak_d;
    logic [NUM_BARS-1:0][TW-1:0] hold_q, hold_d;
    logic [BAR_W-1:0] sh;
    logic [1:0] mode_q;
    logic frame_ev, active, lit_col, in_bar, in_peak, bar_on, peak_on;
    logic [IW-1:0] idx;
    logic [3:0] r_c, g_c, b_c;
    logic hsync_q, vsync_q, fs_q;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        frame_ev = hc_q == H_LAST && vc_q == V_LAST;
        hc_d = hc_q == H_LAST ? '0 : hc_q + 1'b1;
        vc_d = hc_q != H_LAST ? vc_q : vc_q == V_LAST ? '0 : vc_q + 1'b1;
    end

    // Heights and peak updates are computed from the live inputs; they only land on the frame event.
    always_comb begin
        sh = '0;
        h_d = h_q;
        peak_d = peak_q;
        hold_d = hold_q;
        for (int i = 0; i < NUM_BARS; i++) begin
            sh = bars[i] >> SCALE_SHIFT;
            h_d[i] = sh > S_MAX ? P_MAX : PW'(sh);
            peak_d[i] = h_d[i] >= peak_q[i] ? h_d[i] :
                        hold_q[i] != '0 ? peak_q[i] :
                        peak_q[i] > P_DEC ? peak_q[i] - P_DEC : '0;
            hold_d[i] = h_d[i] >= peak_q[i] ? T_HOLD : hold_q[i] != '0 ? hold_q[i] - 1'b1 : '0;
        end
    end

    always_comb begin
        idx = IW'(hc_q / H_BW);
        col = hc_q % H_BW;
        active = hc_q < H_ACT && vc_q < V_ACT;
        lit_col = col < H_LIT;
        bar_top = V_ACT - VW'(h_q[idx]);
        pk_row = V_ACT - VW'(peak_q[idx]);
        in_bar = lit_col && h_q[idx] != '0 && vc_q >= bar_top;
        in_peak = lit_col && peak_q[idx] != '0 && vc_q == pk_row;
        peak_on = active && in_peak && mode_q inside {2'd1, 2'd2};
        bar_on = active && in_bar && !mode_q[1];
        r_c = 4'({idx, 4'b0} >> IW);
        b_c = (vc_q / V_BAND) > V_15 ? 4'hF : 4'(vc_q / V_BAND);
        g_c = 4'(({1'b0, r_c} + {1'b0, b_c}) >> 1);
        rgb_d = peak_on ? 12'hFFF : bar_on ? {r_c, g_c, b_c} : '0;
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= '0;
            vc_q <= '0;
            h_q <= '0;
            peak_q <= '0;
            hold_q <= '0;
            mode_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q <= '0;
            fs_q <= 1'b0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
            if (frame_ev) begin
                h_q <= h_d;
                peak_q <= peak_d;
                hold_q <= hold_d;
                mode_q <= mode;
            end
            hsync_q <= !(hc_q >= HS_ON && hc_q < HS_OFF);
            vsync_q <= !(vc_q >= VS_ON && vc_q < VS_OFF);
            rgb_q <= rgb_d;
            fs_q <= hc_q == '0 && vc_q == '0;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign {red, green, blue} = rgb_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_bar_renderer.sv
// tb_vga_bar_renderer: scoreboard bench for the bar renderer on a shrunken raster
module tb_vga_bar_renderer;
    localparam int HP = 32, HFP = 2, HPU = 4, HBP = 2;
    localparam int VL = 32, VFP = 2, VPU = 2, VBP = 2;
    localparam int NB = 8, SS = 9, GAP = 2, PH = 3, PD = 2;
    localparam int HT = HP + HFP + HPU + HBP;
    localparam int VT = VL + VFP + VPU + VBP;
    localparam int BW = HP / NB;

    logic vgaclk = 1'b0;
    logic rst_n = 1'b1;
    logic [NB-1:0][17:0] bars;
    logic [1:0] mode;
    logic hsync, vsync, frame_start;
    logic [3:0] red, green, blue;
    logic [14:0] dut_v;

    int n_checks, n_errors;
    logic [14:0] exp_q[$];
    int mhc, mvc, mmode, ohc, ovc, hs_low, vs_low, fs_cnt;
    int mh[NB], mpk[NB], mhold[NB];

    initial forever #5 vgaclk = ~vgaclk;

    vga_bar_renderer #(
        .HPIXELS(HP), .HFP(HFP), .HPULSE(HPU), .HBP(HBP),
        .VLINES(VL), .VFP(VFP), .VPULSE(VPU), .VBP(VBP),
        .NUM_BARS(NB), .BAR_W(18), .SCALE_SHIFT(SS), .GAP(GAP),
        .PEAK_HOLD(PH), .PEAK_DECAY(PD)
    ) dut (
        .vgaclk(vgaclk), .rst_n(rst_n), .bars(bars), .mode(mode),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    assign dut_v = {hsync, vsync, frame_start, red, green, blue};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] model_out();
        int idx, col, r, g, b;
        logic hs, vs, fs, pk, br;
        logic [11:0] rgb;
        idx = mhc / BW;
        col = mhc % BW;
        hs = !(mhc >= HP + HFP && mhc < HP + HFP + HPU);
        vs = !(mvc >= VL + VFP && mvc < VL + VFP + VPU);
        fs = mhc == 0 && mvc == 0;
        rgb = '0;
        if (mhc < HP && mvc < VL && col < BW - GAP) begin
            pk = (mmode == 1 || mmode == 2) && mpk[idx] > 0 && mvc == VL - mpk[idx];
            br = (mmode == 0 || mmode == 1) && mh[idx] > 0 && mvc >= VL - mh[idx];
            r = idx * 16 / NB;
            b = mvc / (VL / 16);
            if (b > 15) b = 15;
            g = (r + b) / 2;
            if (pk) rgb = 12'hFFF;
            else if (br) rgb = {4'(r), 4'(g), 4'(b)};
        end
        return {hs, vs, fs, rgb};
    endfunction

    task automatic model_advance();
        if (mhc == HT - 1 && mvc == VT - 1) begin
            for (int i = 0; i < NB; i++) begin
                int h;
                h = int'(bars[i] >> SS);
                if (h > VL) h = VL;
                mh[i] = h;
                if (h >= mpk[i]) begin
                    mpk[i] = h;
                    mhold[i] = PH;
                end else if (mhold[i] > 0) mhold[i]--;
                else mpk[i] = mpk[i] > PD ? mpk[i] - PD : 0;
            end
            mmode = int'(mode);
        end
        if (mhc == HT - 1) begin
            mhc = 0;
            mvc = mvc == VT - 1 ? 0 : mvc + 1;
        end else mhc++;
    endtask

    task automatic model_reset();
        mhc = 0;
        mvc = 0;
        mmode = 0;
        for (int i = 0; i < NB; i++) begin
            mh[i] = 0;
            mpk[i] = 0;
            mhold[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic step();
        logic [14:0] e;
        exp_q.push_back(model_out());
        ohc = mhc;
        ovc = mvc;
        model_advance();
        @(posedge vgaclk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("pix(%0d,%0d)", ohc, ovc), dut_v, e);
        hs_low += int'(!hsync);
        vs_low += int'(!vsync);
        fs_cnt += int'(frame_start);
    endtask

    task automatic run_to(input int h, input int v);
        for (int n = 0; n <= HT * VT; n++) begin
            step();
            if (ohc == h && ovc == v) return;
        end
        check("run_to_timeout", ohc * 1000 + ovc, h * 1000 + v);
    endtask

    task automatic next_frame();
        run_to(HT - 1, VT - 1);
    endtask

    task automatic px(input string tag, input int h, input int v, input logic [11:0] exp);
        run_to(h, v);
        check(tag, {red, green, blue}, exp);
    endtask

    initial begin
        bars = '0;
        mode = 2'd0;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        #2 rst_n = 1'b0;
        @(posedge vgaclk);
        #1;
        check("reset_out", dut_v, 15'h6000);
        @(posedge vgaclk);
        #1 rst_n = 1'b1;
        hs_low = 0;
        vs_low = 0;
        fs_cnt = 0;
        repeat (2 * HT * VT) step();
        check("hsync_low_cycles", hs_low, 2 * VT * HPU);
        check("vsync_low_cycles", vs_low, 2 * VPU * HT);
        check("frame_start_pulses", fs_cnt, 2);

        bars[3] = 18'(10 << SS);
        next_frame();
        px("bar3_above", 12, 21, 12'h000);
        px("bar3_top", 12, 22, 12'h68B);
        px("bar3_bottom", 13, 31, 12'h6AF);
        px("bar3_gap", 14, 31, 12'h000);
        px("bar4_off", 16, 31, 12'h000);

        next_frame();
        run_to(0, 15);
        bars[3] = 18'(20 << SS);
        px("midframe_old", 12, 18, 12'h000);
        next_frame();
        px("midframe_new", 12, 18, 12'h679);

        bars[0] = 18'h3FFFF;
        next_frame();
        px("clamp_row0", 0, 0, 12'h000);
        px("clamp_row31", 1, 31, 12'h07F);
        px("clamp_gap", 2, 31, 12'h000);

        mode = 2'd2;
        next_frame();
        px("mode2_peak0", 0, 0, 12'hFFF);
        px("mode2_peak3", 12, 12, 12'hFFF);
        px("mode2_nobar", 12, 20, 12'h000);

        mode = 2'd3;
        next_frame();
        px("mode3_peak", 12, 12, 12'h000);
        px("mode3_bar", 12, 25, 12'h000);

        bars = '0;
        bars[5] = 18'(8 << SS);
        mode = 2'd1;
        next_frame();
        bars = '0;
        px("pk_pulse_marker", 20, 24, 12'hFFF);
        px("pk_pulse_bar", 20, 25, 12'hABC);
        next_frame();
        px("pk_hold_nobar", 20, 25, 12'h000);
        repeat (3) next_frame();
        px("pk_decay_old", 20, 24, 12'h000);
        px("pk_decay_row", 20, 26, 12'hFFF);
        next_frame();
        px("pk_before_rst", 20, 28, 12'hFFF);

        rst_n = 1'b0;
        #1;
        check("async_reset", dut_v, 15'h6000);
        model_reset();
        repeat (2) @(posedge vgaclk);
        #1 rst_n = 1'b1;
        next_frame();
        px("rst_no_marker24", 20, 24, 12'h000);
        px("rst_no_marker28", 20, 28, 12'h000);
        next_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
